// File: rtl/tmnt_snd_pkg.sv
// Shared sound-block definitions: silence level, theme player FSM states, divider width.
package tmnt_snd_pkg;

    localparam int unsigned THEME_DIV_W = 5;
    localparam logic [7:0]  SND_SILENCE = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FETCH
    } theme_st_t;

endpackage

// File: rtl/theme_tick_div.sv
// Divides the 640 kHz enable by 32 and fires a one-cycle sample tick on a chosen phase.
module theme_tick_div
    import tmnt_snd_pkg::*;
#(
    parameter int unsigned TICK_PHASE = 16
) (
    input  logic main_clk,
    input  logic reset,
    input  logic ce_640k,
    output logic tick_c
);

    logic [THEME_DIV_W-1:0] div;

    // Free-running phase counter, wraps 31 -> 0.
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (ce_640k) begin
            div <= div + THEME_DIV_W'(1);
        end
    end

    assign tick_c = ce_640k & (div == THEME_DIV_W'(TICK_PHASE));

endmodule

// File: rtl/theme_player.sv
// Title-theme PCM player: fetches one ROM byte per 20 kHz tick and holds it as the output sample.
// Optional THEME_VOLUME_EN scales the sample around silence by vol/16.
module theme_player
    import tmnt_snd_pkg::*;
#(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned TICK_PHASE = 16
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              ce_640k,
    input  logic              hold,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    input  logic [3:0]        vol,
    output logic [7:0]        sample,
    output logic              sample_stb,
    output logic              busy,
    output logic              underrun
);

    localparam int unsigned AW1 = ADDR_W + 1;

    theme_st_t      state;
    logic [AW1-1:0] addr;
    logic [AW1-1:0] addr_inc_c;
    logic           tick_c;
    logic [7:0]     level_c;

    theme_tick_div #(
        .TICK_PHASE (TICK_PHASE)
    ) u_tick_div (
        .main_clk (main_clk),
        .reset    (reset),
        .ce_640k  (ce_640k),
        .tick_c   (tick_c)
    );

    // Top address bit doubles as the end-of-theme flag.
    assign rom_addr   = addr[ADDR_W-1:0];
    assign addr_inc_c = addr + AW1'(1);

`ifdef THEME_VOLUME_EN
    logic signed [12:0] centered_c;
    logic signed [12:0] scaled_c;

    always_comb begin
        centered_c = $signed({{5{~rom_data[7]}}, ~rom_data[7], rom_data[6:0]});
        scaled_c   = (centered_c * $signed({9'd0, vol})) >>> 4;
        level_c    = scaled_c[7:0] + SND_SILENCE;
    end
`else
    logic unused_vol;

    assign unused_vol = ^vol;
    assign level_c    = rom_data;
`endif

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            rom_req    <= 1'b0;
            sample     <= SND_SILENCE;
            sample_stb <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            if (hold) begin
                // Rewind and mute; an ack landing in this cycle is dropped.
                state    <= IDLE;
                addr     <= '0;
                rom_req  <= 1'b0;
                sample   <= SND_SILENCE;
                busy     <= 1'b0;
                underrun <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sample <= SND_SILENCE;
                        busy   <= 1'b0;
                        if (!addr[ADDR_W]) begin
                            state <= WAIT;
                            busy  <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (tick_c) begin
                            state   <= FETCH;
                            rom_req <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (tick_c) begin
                            underrun <= 1'b1;
                        end
                        if (rom_ack) begin
                            rom_req    <= 1'b0;
                            sample     <= level_c;
                            sample_stb <= 1'b1;
                            addr       <= addr_inc_c;
                            state      <= addr_inc_c[ADDR_W] ? IDLE : WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_theme_player.sv
// Bench for theme_player (ADDR_W = 4): random ROM contents and ack latency against a sample-sequence model.
module tb_theme_player;

    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ce_640k = 1'b0;
    logic              hold = 1'b1;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_req;
    logic              rom_ack = 1'b0;
    logic [7:0]        rom_data = 8'h00;
    logic [3:0]        vol = 4'h0;
    logic [7:0]        sample;
    logic              sample_stb;
    logic              busy;
    logic              underrun;

    theme_player #(
        .ADDR_W     (ADDR_W),
        .TICK_PHASE (16)
    ) dut (
        .main_clk   (clk),
        .reset      (reset),
        .ce_640k    (ce_640k),
        .hold       (hold),
        .rom_addr   (rom_addr),
        .rom_req    (rom_req),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .vol        (vol),
        .sample     (sample),
        .sample_stb (sample_stb),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [16];
    int passed = 0;
    int total = 0;
    int cyc_n = 0;
    int ce_n = 0;
    int ack_cyc = -10;
    int last_stb_ce = 0;
    int exp_idx = 0;
    int stb_count = 0;
    int req_cnt = 0;
    int lat_left = 0;
    logic [7:0] last_val = 8'h80;
    bit space_en = 1'b1;
    bit space_ok = 1'b0;
    bit in_req = 1'b0;
    bit rand_lat = 1'b0;
    bit long_once = 1'b0;
    bit never_ack = 1'b0;
    bit hold_on_ack = 1'b0;

    // Expected output byte for a ROM byte: identity, or signed scaling by vol/16 around 0x80.
    function automatic logic [7:0] exp_sample(input logic [7:0] d);
`ifdef THEME_VOLUME_EN
        int v;
        v = (int'(d) - 128) * int'(vol);
        v = v >>> 4;
        return 8'(v + 128);
`else
        return d;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: observe outputs after the edge, then drive ce and the ROM responder.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        if (sample_stb) begin
            chk("stb_value", 32'(sample), 32'(exp_sample(rom[exp_idx[3:0]])));
            chk("stb_latency", 32'(cyc_n - ack_cyc), 32'd1);
            if (space_ok) chk("stb_spacing", 32'(ce_n - last_stb_ce), 32'd32);
            last_stb_ce = ce_n;
            space_ok = space_en;
            last_val = sample;
            exp_idx++;
            stb_count++;
        end
        if (rom_req) req_cnt++;
        ce_640k = (cyc_n % 4 == 0);
        if (ce_640k) ce_n++;
        if (rom_ack || reset) begin
            rom_ack = 1'b0;
            if (reset) in_req = 1'b0;
        end else if (rom_req && !never_ack) begin
            if (!in_req) begin
                in_req = 1'b1;
                if (long_once) begin
                    lat_left = 170;
                    long_once = 1'b0;
                end else if (rand_lat) begin
                    lat_left = $urandom_range(0, 100);
                end else begin
                    lat_left = 0;
                end
            end
            if (lat_left == 0) begin
                chk("rom_addr", 32'(rom_addr), 32'(exp_idx[3:0]));
                rom_ack = 1'b1;
                rom_data = rom[rom_addr];
                ack_cyc = cyc_n;
                in_req = 1'b0;
                if (hold_on_ack) begin
                    hold = 1'b1;
                    hold_on_ack = 1'b0;
                end
            end else begin
                lat_left--;
            end
        end
    endtask

    task automatic wait_stb(input int limit);
        int target;
        target = stb_count + 1;
        for (int i = 0; i < limit && stb_count < target; i++) cyc();
        chk("stb_arrived", 32'(stb_count), 32'(target));
    endtask

    initial begin
        vol = 4'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);

        // Reset values.
        cyc();
        cyc();
        chk("rst_req", 32'(rom_req), 32'd0);
        chk("rst_sample", 32'(sample), 32'h80);
        chk("rst_stb", 32'(sample_stb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);

        reset = 1'b0;
        repeat (3) cyc();
        chk("hold_busy", 32'(busy), 32'd0);

        // Full theme at zero ack latency, strobes 32 ce pulses apart.
        hold = 1'b0;
        for (int i = 0; i < 16; i++) wait_stb(600);
        repeat (3) cyc();
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_sample", 32'(sample), 32'h80);
        req_cnt = 0;
        repeat (300) cyc();
        chk("done_no_req", 32'(req_cnt), 32'd0);
        chk("done_stb_count", 32'(stb_count), 32'd16);

        // Hold pulse restarts from address 0.
        hold = 1'b1;
        repeat (3) cyc();
        chk("hold_addr", 32'(rom_addr), 32'd0);
        chk("hold_busy2", 32'(busy), 32'd0);
        hold = 1'b0;
        exp_idx = 0;
        space_en = 1'b0;
        space_ok = 1'b0;
        rand_lat = 1'b1;
        repeat (3) cyc();
        chk("restart_busy", 32'(busy), 32'd1);
        wait_stb(600);
        wait_stb(600);

        // One fetch delayed past the next tick.
        long_once = 1'b1;
        for (int i = 0; i < 600 && !underrun; i++) cyc();
        chk("underrun_set", 32'(underrun), 32'd1);
        chk("underrun_sample", 32'(sample), 32'(last_val));
        wait_stb(600);
        wait_stb(600);
        chk("underrun_sticky", 32'(underrun), 32'd1);

        // Hold coincident with ack: ack dropped, mute, rewind.
        hold_on_ack = 1'b1;
        for (int i = 0; i < 600 && !hold; i++) cyc();
        chk("hold_ack_seen", 32'(hold), 32'd1);
        cyc();
        chk("hold_ack_stb", 32'(sample_stb), 32'd0);
        chk("hold_ack_sample", 32'(sample), 32'h80);
        chk("hold_ack_addr", 32'(rom_addr), 32'd0);
        chk("hold_ack_req", 32'(rom_req), 32'd0);
        chk("hold_ack_underrun", 32'(underrun), 32'd0);
        hold = 1'b0;
        exp_idx = 0;
        space_ok = 1'b0;
        wait_stb(600);
        wait_stb(600);

        // Asynchronous reset in the middle of a fetch.
        never_ack = 1'b1;
        for (int i = 0; i < 600 && !rom_req; i++) cyc();
        chk("fetch_pending", 32'(rom_req), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_req", 32'(rom_req), 32'd0);
        chk("async_sample", 32'(sample), 32'h80);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_addr", 32'(rom_addr), 32'd0);
        chk("async_underrun", 32'(underrun), 32'd0);
        chk("async_stb", 32'(sample_stb), 32'd0);
        repeat (2) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
